// File: rtl/mont_arb_pkg.sv
// Shared types and defaults for the montgomery multiplier arbiter.
package mont_arb_pkg;

    localparam int unsigned WIDTH_DEF   = 1024;
    localparam int unsigned TIMEOUT_DEF = 8191;
    localparam int unsigned WD_W        = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        START = 3'd2,
        BUSY  = 3'd3,
        RESP  = 3'd4
    } state_t;

    // Index width for n requesters, never below one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mont_mul_arbiter_rr.sv
// Combinational round-robin pick: first valid requester at or after ptr, wrapping.
module rr_arbiter_n
    import mont_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 2,
    parameter int unsigned IDX_W = idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] grant_c,
    output logic [IDX_W-1:0] grant_idx_c,
    output logic             any_c
);

    logic [IDX_W-1:0] cand [N_REQ];

    // Search order: ptr, ptr+1, ... modulo N_REQ.
    for (genvar g = 0; g < N_REQ; g++) begin : g_cand
        assign cand[g] = IDX_W'((32'(ptr) + 32'(g)) % N_REQ);
    end

    always_comb begin
        grant_c     = '0;
        grant_idx_c = '0;
        any_c       = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!any_c && req[cand[k]]) begin
                any_c             = 1'b1;
                grant_idx_c       = cand[k];
                grant_c[cand[k]]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mont_mul_arbiter.sv
// Shares one montgomery2 core among N_REQ requesters: round-robin accept,
// core sequencing (reset release, start, wait done), watchdog abort, one-cycle response.
module mont_mul_arbiter
    import mont_arb_pkg::*;
#(
    parameter int unsigned N_REQ   = 2,
    parameter int unsigned WIDTH   = WIDTH_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    input  logic [N_REQ*WIDTH-1:0] req_m,
    output logic [N_REQ-1:0]       req_ready,
    output logic [N_REQ-1:0]       rsp_valid,
    output logic                   rsp_err,
    output logic [WIDTH-1:0]       rsp_result,
    output logic                   mul_resetn,
    output logic                   mul_start,
    output logic [WIDTH-1:0]       mul_a,
    output logic [WIDTH-1:0]       mul_b,
    output logic [WIDTH-1:0]       mul_m,
    input  logic [WIDTH-1:0]       mul_result,
    input  logic                   mul_done
);

    localparam int unsigned     IDX_W    = idx_w(N_REQ);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] owner;
    logic [WD_W-1:0]  wd;
    logic [WD_W-1:0]  wd_inc_c;
    logic [N_REQ-1:0] grant_c;
    logic [IDX_W-1:0] grant_idx_c;
    logic             any_c;
    logic             accept_c;

    logic [WIDTH-1:0] a_arr [N_REQ];
    logic [WIDTH-1:0] b_arr [N_REQ];
    logic [WIDTH-1:0] m_arr [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign a_arr[g] = req_a[g*WIDTH +: WIDTH];
        assign b_arr[g] = req_b[g*WIDTH +: WIDTH];
        assign m_arr[g] = req_m[g*WIDTH +: WIDTH];
    end

    rr_arbiter_n #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req         (req_valid),
        .ptr         (ptr),
        .grant_c     (grant_c),
        .grant_idx_c (grant_idx_c),
        .any_c       (any_c)
    );

    // The accept handshake must complete in the cycle req_valid is seen.
    assign accept_c  = (state == IDLE) && any_c && !reset;
    assign req_ready = grant_c & {N_REQ{accept_c}};

    // Next-state logic; done is only honoured in BUSY, and wins over the watchdog.
    always_comb begin
        state_nxt = state;
        wd_inc_c  = wd + WD_W'(1);
        case (state)
            IDLE:    if (any_c) state_nxt = LOAD;
            LOAD:    state_nxt = START;
            START:   state_nxt = BUSY;
            BUSY:    if (mul_done || (wd_inc_c == WD_LIMIT)) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            ptr        <= '0;
            owner      <= '0;
            wd         <= '0;
            mul_a      <= '0;
            mul_b      <= '0;
            mul_m      <= '0;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
            rsp_valid  <= '0;
            mul_start  <= 1'b0;
            mul_resetn <= 1'b0;
        end else begin
            state      <= state_nxt;
            mul_resetn <= (state_nxt != IDLE);
            mul_start  <= (state_nxt == START);
            rsp_valid  <= (state_nxt == RESP) ? (N_REQ'(1) << owner) : '0;

            if (accept_c) begin
                owner <= grant_idx_c;
                ptr   <= (grant_idx_c == LAST_IDX) ? '0 : grant_idx_c + IDX_W'(1);
                mul_a <= a_arr[grant_idx_c];
                mul_b <= b_arr[grant_idx_c];
                mul_m <= m_arr[grant_idx_c];
            end

            if (state == START) begin
                wd <= '0;
            end

            // Watchdog saturates at the limit because BUSY is left on that cycle.
            if (state == BUSY) begin
                if (mul_done) begin
                    rsp_result <= mul_result;
                    rsp_err    <= 1'b0;
                end else begin
                    wd <= wd_inc_c;
                    if (wd_inc_c == WD_LIMIT) begin
                        rsp_result <= '0;
                        rsp_err    <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
